// File: rtl/fpu_float_to_int_pipe.sv
// fpu_float_to_int_pipe: three-stage IEEE float to 32-bit integer converter
// (FCVT.W.S / FCVT.WU.S class) with a valid/ready handshake on both sides.
//   S1: unpack and classify, form the significand and the unbiased exponent
//   S2: align the significand, extract integer part and guard/round/sticky
//   S3: round, negate, saturate and raise invalid/inexact
// Optional feature macro F2I_SKID_BUFFER_EN: adds a 2-entry output skid
// buffer so that output_ready is registered and has no combinational path
// from input_ready.
module fpu_float_to_int_pipe #(
    parameter int std  = 31,
    parameter int man  = 22,
    parameter int exp  = 7,
    parameter int bias = 127
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           FLOAT_TO_INT_input_valid,
    output logic           FLOAT_TO_INT_output_ready,
    input  logic [std:0]   FLOAT_TO_INT_input_float,
    input  logic [2:0]     FLOAT_TO_INT_input_rm,
    input  logic           FLOAT_TO_INT_input_opcode_FI,
    input  logic           FLOAT_TO_INT_input_opcode_signed,
    input  logic           FLOAT_TO_INT_input_opcode_unsigned,
    output logic           FLOAT_TO_INT_output_valid,
    input  logic           FLOAT_TO_INT_input_ready,
    output logic [31:0]    FLOAT_TO_INT_output_int,
    output logic           FLOAT_TO_INT_output_invalid_flag,
    output logic           FLOAT_TO_INT_output_inexact_flag
);

    localparam int SW = man + 2;   // significand width including hidden bit
    localparam int EW = exp + 2;   // signed unbiased exponent width

    localparam logic signed [EW-1:0] BIAS_S = EW'(bias);
    localparam logic signed [EW-1:0] E_MAX  = EW'(31);
    localparam logic signed [EW-1:0] E_M1   = EW'(-1);
    localparam logic signed [EW-1:0] E_M2   = EW'(-2);

    // ---------------- S1 decode ----------------
    logic [exp:0]          exp_fld_s;
    logic [man:0]          man_fld_s;
    logic                  is_nan_s, is_inf_s, is_zero_s, tgt_signed_s;
    logic [SW-1:0]         sig_s;
    logic signed [EW-1:0]  e_s;
    logic                  pipe_adv_s;

    logic                  s1_valid_r, s1_sign_r, s1_nan_r, s1_inf_r, s1_zero_r;
    logic                  s1_signed_r, s1_fi_r;
    logic [2:0]            s1_rm_r;
    logic [SW-1:0]         s1_sig_r;
    logic signed [EW-1:0]  s1_e_r;

    // Unpack the operand fields and classify the special encodings.
    always_comb begin
        exp_fld_s = FLOAT_TO_INT_input_float[std-1:man+1];
        man_fld_s = FLOAT_TO_INT_input_float[man:0];
        is_nan_s  = (&exp_fld_s) & (|man_fld_s);
        is_inf_s  = (&exp_fld_s) & ~(|man_fld_s);
        is_zero_s = ~(|exp_fld_s) & ~(|man_fld_s);
        // Subnormals get no hidden bit; their magnitude is always below one.
        sig_s     = {(|exp_fld_s), man_fld_s};
        e_s       = $signed({1'b0, exp_fld_s}) - BIAS_S;
        // Signed target wins when both opcode bits are set.
        case ({FLOAT_TO_INT_input_opcode_signed, FLOAT_TO_INT_input_opcode_unsigned})
            2'b10, 2'b11: tgt_signed_s = 1'b1;
            2'b01:        tgt_signed_s = 1'b0;
            default:      tgt_signed_s = 1'b0;
        endcase
    end

    // ---------------- S2 alignment ----------------
    logic [SW+31:0]  sh_s;
    logic [31:0]     int_s;
    logic            g_s, r_s, st_s, large_s;

    logic            s2_valid_r, s2_sign_r, s2_nan_r, s2_inf_r, s2_zero_r;
    logic            s2_signed_r, s2_fi_r, s2_large_r, s2_g_r, s2_r_r, s2_s_r;
    logic [2:0]      s2_rm_r;
    logic [31:0]     s2_int_r;

    // Place the integer part in 32 bits and collect G/R/S from what falls below.
    always_comb begin
        sh_s    = {{32{1'b0}}, s1_sig_r} << s1_e_r[4:0];
        int_s   = 32'd0;
        g_s     = 1'b0;
        r_s     = 1'b0;
        st_s    = 1'b0;
        large_s = 1'b0;
        if (s1_e_r > E_MAX) begin
            large_s = 1'b1;
        end else if (!s1_e_r[EW-1]) begin
            int_s = sh_s[SW+30:SW-1];
            g_s   = sh_s[SW-2];
            r_s   = sh_s[SW-3];
            st_s  = |sh_s[SW-4:0];
        end else if (s1_e_r == E_M1) begin
            g_s  = s1_sig_r[SW-1];
            r_s  = s1_sig_r[SW-2];
            st_s = |s1_sig_r[SW-3:0];
        end else if (s1_e_r == E_M2) begin
            r_s  = s1_sig_r[SW-1];
            st_s = |s1_sig_r[SW-2:0];
        end else begin
            st_s = |s1_sig_r;
        end
    end

    // ---------------- S3 round / saturate ----------------
    logic        inc_s, grs_s;
    logic [32:0] mag_s;
    logic [31:0] res_int_s;
    logic        res_nv_s, res_nx_s;

    // Round the magnitude, then apply sign, saturation and flag rules.
    always_comb begin
        grs_s = s2_g_r | s2_r_r | s2_s_r;
        case (s2_rm_r)
            3'b000:  inc_s = s2_g_r & (s2_r_r | s2_s_r | s2_int_r[0]);
            3'b001:  inc_s = 1'b0;
            3'b010:  inc_s = s2_sign_r & grs_s;
            3'b011:  inc_s = ~s2_sign_r & grs_s;
            3'b100:  inc_s = s2_g_r;
            default: inc_s = 1'b0;
        endcase
        mag_s     = {1'b0, s2_int_r} + {32'd0, inc_s};
        res_int_s = 32'd0;
        res_nv_s  = 1'b0;
        res_nx_s  = 1'b0;
        if (!s2_valid_r || !s2_fi_r) begin
            res_int_s = 32'd0;
        end else if (s2_rm_r > 3'd4) begin
            res_nv_s = 1'b1;
        end else if (s2_nan_r) begin
            res_int_s = s2_signed_r ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            res_nv_s  = 1'b1;
        end else if (s2_inf_r || s2_large_r) begin
            if (s2_sign_r) begin
                res_int_s = s2_signed_r ? 32'h8000_0000 : 32'h0000_0000;
            end else begin
                res_int_s = s2_signed_r ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            end
            res_nv_s = 1'b1;
        end else if (s2_zero_r) begin
            res_int_s = 32'd0;
        end else if (s2_signed_r) begin
            if (!s2_sign_r && (mag_s > 33'h0_7FFF_FFFF)) begin
                res_int_s = 32'h7FFF_FFFF;
                res_nv_s  = 1'b1;
            end else if (s2_sign_r && (mag_s > 33'h0_8000_0000)) begin
                res_int_s = 32'h8000_0000;
                res_nv_s  = 1'b1;
            end else begin
                res_int_s = s2_sign_r ? (~mag_s[31:0] + 32'd1) : mag_s[31:0];
                res_nx_s  = grs_s;
            end
        end else begin
            if (s2_sign_r && (mag_s != 33'd0)) begin
                res_nv_s = 1'b1;
            end else if (mag_s[32]) begin
                res_int_s = 32'hFFFF_FFFF;
                res_nv_s  = 1'b1;
            end else begin
                res_int_s = s2_sign_r ? 32'd0 : mag_s[31:0];
                res_nx_s  = grs_s;
            end
        end
    end

    // Advance S1 and S2 together; the whole pipe holds when the output cannot move.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            s1_valid_r <= 1'b0; s1_sign_r <= 1'b0; s1_nan_r <= 1'b0;
            s1_inf_r   <= 1'b0; s1_zero_r <= 1'b0; s1_signed_r <= 1'b0;
            s1_fi_r    <= 1'b0; s1_rm_r   <= 3'd0; s1_sig_r <= '0;
            s1_e_r     <= '0;
            s2_valid_r <= 1'b0; s2_sign_r <= 1'b0; s2_nan_r <= 1'b0;
            s2_inf_r   <= 1'b0; s2_zero_r <= 1'b0; s2_signed_r <= 1'b0;
            s2_fi_r    <= 1'b0; s2_large_r <= 1'b0; s2_g_r <= 1'b0;
            s2_r_r     <= 1'b0; s2_s_r    <= 1'b0; s2_rm_r <= 3'd0;
            s2_int_r   <= 32'd0;
        end else if (pipe_adv_s) begin
            s1_valid_r  <= FLOAT_TO_INT_input_valid;
            s1_sign_r   <= FLOAT_TO_INT_input_float[std];
            s1_nan_r    <= is_nan_s;
            s1_inf_r    <= is_inf_s;
            s1_zero_r   <= is_zero_s;
            s1_signed_r <= tgt_signed_s;
            s1_fi_r     <= FLOAT_TO_INT_input_opcode_FI;
            s1_rm_r     <= FLOAT_TO_INT_input_rm;
            s1_sig_r    <= sig_s;
            s1_e_r      <= e_s;
            s2_valid_r  <= s1_valid_r;
            s2_sign_r   <= s1_sign_r;
            s2_nan_r    <= s1_nan_r;
            s2_inf_r    <= s1_inf_r;
            s2_zero_r   <= s1_zero_r;
            s2_signed_r <= s1_signed_r;
            s2_fi_r     <= s1_fi_r;
            s2_large_r  <= large_s;
            s2_g_r      <= g_s;
            s2_r_r      <= r_s;
            s2_s_r      <= st_s;
            s2_rm_r     <= s1_rm_r;
            s2_int_r    <= int_s;
        end
    end

    logic        out_valid_r, out_nv_r, out_nx_r;
    logic [31:0] out_int_r;

`ifdef F2I_SKID_BUFFER_EN
    logic        sk_valid_r, sk_nv_r, sk_nx_r, ready_r;
    logic [31:0] sk_int_r;
    logic        push_s, pop_s, full_next_s;

    // Pipe moves whenever the two-entry output buffer is not full.
    always_comb begin
        pipe_adv_s  = ready_r;
        push_s      = s2_valid_r & ready_r;
        pop_s       = out_valid_r & FLOAT_TO_INT_input_ready;
        full_next_s = (sk_valid_r & ~pop_s) | (out_valid_r & ~sk_valid_r & ~pop_s & push_s);
    end

    // Head register drives the outputs; the skid entry catches one result during a stall.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            out_valid_r <= 1'b0; out_int_r <= 32'd0; out_nv_r <= 1'b0; out_nx_r <= 1'b0;
            sk_valid_r  <= 1'b0; sk_int_r  <= 32'd0; sk_nv_r  <= 1'b0; sk_nx_r  <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            if (sk_valid_r) begin
                if (pop_s) begin
                    out_int_r  <= sk_int_r;
                    out_nv_r   <= sk_nv_r;
                    out_nx_r   <= sk_nx_r;
                    sk_valid_r <= 1'b0;
                end
            end else if (out_valid_r && !pop_s) begin
                if (push_s) begin
                    sk_valid_r <= 1'b1;
                    sk_int_r   <= res_int_s;
                    sk_nv_r    <= res_nv_s;
                    sk_nx_r    <= res_nx_s;
                end
            end else begin
                out_valid_r <= push_s;
                out_int_r   <= push_s ? res_int_s : 32'd0;
                out_nv_r    <= push_s & res_nv_s;
                out_nx_r    <= push_s & res_nx_s;
            end
            ready_r <= ~full_next_s;
        end
    end

    assign FLOAT_TO_INT_output_ready = ready_r;
`else
    logic stall_s;

    // A result waiting on downstream freezes every stage.
    always_comb begin
        stall_s    = out_valid_r & ~FLOAT_TO_INT_input_ready;
        pipe_adv_s = ~stall_s;
    end

    // Output register; holds its contents while stalled.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            out_valid_r <= 1'b0; out_int_r <= 32'd0; out_nv_r <= 1'b0; out_nx_r <= 1'b0;
        end else if (pipe_adv_s) begin
            out_valid_r <= s2_valid_r;
            out_int_r   <= res_int_s;
            out_nv_r    <= res_nv_s;
            out_nx_r    <= res_nx_s;
        end
    end

    assign FLOAT_TO_INT_output_ready = ~stall_s;
`endif

    assign FLOAT_TO_INT_output_valid        = out_valid_r;
    assign FLOAT_TO_INT_output_int          = out_int_r;
    assign FLOAT_TO_INT_output_invalid_flag = out_nv_r;
    assign FLOAT_TO_INT_output_inexact_flag = out_nx_r;

endmodule

// File: tb/tb_fpu_float_to_int_pipe.sv
// Self-checking bench for fpu_float_to_int_pipe: directed cases, a stalled
// stream, reset with operands in flight, and a randomized run scored against
// an arithmetic reference model (truncate, compare remainder with one half).
module tb_fpu_float_to_int_pipe;

    logic        clk = 1'b0;
    logic        rst_l = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready;
    logic [31:0] in_float = 32'd0;
    logic [2:0]  in_rm = 3'd0;
    logic        op_fi = 1'b1, op_s = 1'b1, op_u = 1'b0;
    logic        out_valid;
    logic        in_ready = 1'b1;
    logic [31:0] out_int;
    logic        out_nv, out_nx;

    fpu_float_to_int_pipe dut (
        .clk                               (clk),
        .rst_l                             (rst_l),
        .FLOAT_TO_INT_input_valid          (in_valid),
        .FLOAT_TO_INT_output_ready         (out_ready),
        .FLOAT_TO_INT_input_float          (in_float),
        .FLOAT_TO_INT_input_rm             (in_rm),
        .FLOAT_TO_INT_input_opcode_FI      (op_fi),
        .FLOAT_TO_INT_input_opcode_signed  (op_s),
        .FLOAT_TO_INT_input_opcode_unsigned(op_u),
        .FLOAT_TO_INT_output_valid         (out_valid),
        .FLOAT_TO_INT_input_ready          (in_ready),
        .FLOAT_TO_INT_output_int           (out_int),
        .FLOAT_TO_INT_output_invalid_flag  (out_nv),
        .FLOAT_TO_INT_output_inexact_flag  (out_nx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        logic        nv;
        logic        nx;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
    int          hold_lo = 0;
    bit          mon_en = 1'b1;
    bit          accepted = 1'b0;
    bit          stalled_prev = 1'b0;
    bit          pend_const = 1'b0;
    bit          pend_lat = 1'b0;
    logic [33:0] pend_exp = 34'd0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    // Reference: value = m * 2^k; round by comparing the dropped remainder with one half.
    function automatic logic [33:0] ref_model(input logic [31:0] f, input logic [2:0] rm,
                                              input logic fi, input logic sg);
        logic   neg;
        longint m, trunc, rem, half, mag, val;
        int     k;
        bit     inexact, up;
        if (!fi) return 34'd0;
        if (rm > 3'd4) return {2'b10, 32'd0};
        neg = f[31];
        if (f[30:23] == 8'hFF) begin
            if (f[22:0] != 23'd0) return {2'b10, (sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF)};
            if (neg) return {2'b10, (sg ? 32'h8000_0000 : 32'h0000_0000)};
            return {2'b10, (sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF)};
        end
        if (f[30:23] == 8'h00) begin
            m = longint'(f[22:0]);
            k = -149;
        end else begin
            m = longint'({1'b1, f[22:0]});
            k = int'(f[30:23]) - 150;
        end
        if (k >= 0) begin
            trunc = (k > 20) ? (longint'(1) << 40) : (m << k);
            rem   = 0;
            half  = 1;
        end else if (k < -40) begin
            trunc = 0;
            rem   = m;
            half  = longint'(1) << 40;
        end else begin
            trunc = m >> (-k);
            rem   = m - (trunc << (-k));
            half  = longint'(1) << (-k - 1);
        end
        inexact = (rem != 0);
        case (rm)
            3'd0:    up = (rem > half) || ((rem == half) && (trunc % 2 == 1));
            3'd2:    up = neg && inexact;
            3'd3:    up = !neg && inexact;
            3'd4:    up = (rem >= half);
            default: up = 1'b0;
        endcase
        mag = trunc + (up ? 1 : 0);
        if (sg) begin
            if (!neg && mag > 64'sd2147483647) return {2'b10, 32'h7FFF_FFFF};
            if (neg && mag > 64'sd2147483648) return {2'b10, 32'h8000_0000};
            val = neg ? -mag : mag;
            return {1'b0, inexact, val[31:0]};
        end
        if (neg && mag != 0) return {2'b10, 32'd0};
        if (mag > 64'sd4294967295) return {2'b10, 32'hFFFF_FFFF};
        return {1'b0, inexact, mag[31:0]};
    endfunction

    // One clock: choose backpressure, observe at the falling edge, return #1 after the rise.
    task automatic tick();
        exp_t        e;
        logic [33:0] r;
        if (hold_lo > 0) begin
            in_ready = 1'b0;
            hold_lo--;
        end else if (rdy_mode == 1) begin
            in_ready = ($urandom_range(0, 3) != 0);
        end else begin
            in_ready = (rdy_mode != 2);
        end
        @(negedge clk);
        cyc++;
        accepted = 1'b0;
        if (mon_en) begin
            if (stalled_prev) check("stall_hold_valid", 64'(out_valid), 64'd1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("out_without_entry", 64'(out_valid), 64'd0);
                end else begin
                    e = q[0];
                    check("result_int", 64'(out_int), 64'(e.v));
                    check("invalid_flag", 64'(out_nv), 64'(e.nv));
                    check("inexact_flag", 64'(out_nx), 64'(e.nx));
                    if (in_ready) begin
                        if (e.lat) check("latency", 64'(cyc - e.acc), 64'd3);
                        void'(q.pop_front());
                    end
                end
            end
            stalled_prev = out_valid & ~in_ready;
            if (in_valid && out_ready) begin
                r     = pend_const ? pend_exp : ref_model(in_float, in_rm, op_fi, op_s);
                e.v   = r[31:0];
                e.nx  = r[32];
                e.nv  = r[33];
                e.acc = cyc;
                e.lat = pend_lat;
                q.push_back(e);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] f, input logic [2:0] rm, input logic fi,
                        input logic sg, input logic us, input bit use_c,
                        input logic [33:0] expv, input bit lat);
        in_valid   = 1'b1;
        in_float   = f;
        in_rm      = rm;
        op_fi      = fi;
        op_s       = sg;
        op_u       = us;
        pend_const = use_c;
        pend_exp   = expv;
        pend_lat   = lat;
        accepted   = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (accepted) break;
        end
        check("accept_timeout", 64'(accepted), 64'd1);
    endtask

    // Directed operand sent from an empty pipe with a fixed expected {nv,nx,int}.
    task automatic dir(input logic [31:0] f, input logic [2:0] rm, input logic sg,
                       input logic us, input logic fi, input logic [33:0] expv);
        send(f, rm, fi, sg, us, 1'b1, expv, 1'b1);
        idle(5);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 200 && q.size() != 0; n++) tick();
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_float();
        int          r;
        logic [31:0] f;
        logic [7:0]  e;
        r = $urandom_range(0, 19);
        f = $urandom;
        if (r == 0) begin
            case ($urandom_range(0, 5))
                0:       f = {f[31], 31'd0};
                1:       f = {f[31], 8'hFF, 23'd0};
                2:       f = {f[31], 8'hFF, f[22:1], 1'b1};
                3:       f = {f[31], 8'h00, f[22:0]};
                4:       f = {f[31], 8'h9E, 23'd0};
                default: f = {f[31], 8'h9D, 23'h7F_FFFF};
            endcase
        end else begin
            e = 8'($urandom_range(110, 162));
            f[30:23] = e;
            if (r < 6) f[14:0] = 15'd0;
        end
        return f;
    endfunction

    initial begin
        logic [2:0] rm;
        int         rr;
        repeat (3) @(posedge clk);
        #1;
        rst_l = 1'b0;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_int", 64'(out_int), 64'd0);
        check("reset_flags", 64'({out_nv, out_nx}), 64'd0);
        check("reset_ready", 64'(out_ready), 64'd1);
        idle(2);

        // Directed boundary cases: f, rm, signed, unsigned, fi, {nv,nx,int}
        dir(32'h3FC0_0000, 3'd0, 1'b1, 1'b0, 1'b1, {2'b01, 32'h0000_0002});
        dir(32'h4020_0000, 3'd0, 1'b1, 1'b0, 1'b1, {2'b01, 32'h0000_0002});
        dir(32'hC020_0000, 3'd2, 1'b1, 1'b0, 1'b1, {2'b01, 32'hFFFF_FFFD});
        dir(32'h4F00_0000, 3'd0, 1'b1, 1'b0, 1'b1, {2'b10, 32'h7FFF_FFFF});
        dir(32'h4F00_0000, 3'd0, 1'b0, 1'b1, 1'b1, {2'b00, 32'h8000_0000});
        dir(32'h4F00_0000, 3'd0, 1'b1, 1'b1, 1'b1, {2'b10, 32'h7FFF_FFFF});
        dir(32'h4F00_0000, 3'd0, 1'b0, 1'b0, 1'b1, {2'b00, 32'h8000_0000});
        dir(32'hCF00_0000, 3'd0, 1'b1, 1'b0, 1'b1, {2'b00, 32'h8000_0000});
        dir(32'h7FC0_0000, 3'd0, 1'b1, 1'b0, 1'b1, {2'b10, 32'h7FFF_FFFF});
        dir(32'hBF80_0000, 3'd0, 1'b0, 1'b1, 1'b1, {2'b10, 32'h0000_0000});
        dir(32'hBE99_999A, 3'd1, 1'b0, 1'b1, 1'b1, {2'b01, 32'h0000_0000});
        dir(32'h8000_0000, 3'd0, 1'b1, 1'b0, 1'b1, {2'b00, 32'h0000_0000});
        dir(32'hFF80_0000, 3'd0, 1'b1, 1'b0, 1'b1, {2'b10, 32'h8000_0000});
        dir(32'h7F80_0000, 3'd0, 1'b0, 1'b1, 1'b1, {2'b10, 32'hFFFF_FFFF});
        dir(32'h3F00_0000, 3'd0, 1'b1, 1'b0, 1'b1, {2'b01, 32'h0000_0000});
        dir(32'h3F00_0000, 3'd4, 1'b1, 1'b0, 1'b1, {2'b01, 32'h0000_0001});
        dir(32'h3FC0_0000, 3'd5, 1'b1, 1'b0, 1'b1, {2'b10, 32'h0000_0000});
        dir(32'h3FC0_0000, 3'd0, 1'b1, 1'b0, 1'b0, {2'b00, 32'h0000_0000});

        // Back-to-back stream of 8 with a 5-cycle downstream stall in the middle.
        for (int i = 0; i < 8; i++) begin
            if (i == 4) hold_lo = 5;
            send(rand_float(), 3'($urandom_range(0, 4)), 1'b1, 1'($urandom_range(0, 1)),
                 1'b0, 1'b0, 34'd0, 1'b0);
        end
        drain();

        // Reset with three operands in flight.
        rdy_mode = 2;
        for (int i = 0; i < 3; i++)
            send(32'h4228_0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 34'd0, 1'b0);
        in_valid = 1'b0;
        mon_en   = 1'b0;
        rst_l    = 1'b1;
        tick();
        rst_l = 1'b0;
        q.delete();
        stalled_prev = 1'b0;
        check("midreset_valid", 64'(out_valid), 64'd0);
        check("midreset_int", 64'(out_int), 64'd0);
        check("midreset_ready", 64'(out_ready), 64'd1);
        mon_en   = 1'b1;
        rdy_mode = 0;
        idle(5);
        dir(32'h4228_0000, 3'd0, 1'b1, 1'b0, 1'b1, {2'b00, 32'h0000_002A});

        // Randomized traffic with random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            rr = $urandom_range(0, 9);
            rm = (rr > 7) ? 3'd0 : 3'(rr);
            send(rand_float(), rm, ($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, 34'd0, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
